// File: rtl/rename_nway.sv
// Multi-way register-rename stage: speculative F-RAT, retirement R-RAT and phys busy table.
// Optional stall counters are enabled by defining RENAME_PERF_EN.
module rename_nway #(
    parameter int unsigned WIDTH    = 2,
    parameter int unsigned LOG_ARCH = 5,
    parameter int unsigned LOG_PHYS = 6
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic [WIDTH-1:0]             In_valid,
    input  logic [WIDTH*LOG_ARCH-1:0]    In_srcA,
    input  logic [WIDTH*LOG_ARCH-1:0]    In_srcB,
    input  logic [WIDTH*LOG_ARCH-1:0]    In_dst,
    input  logic [WIDTH-1:0]             In_regwrite,
    output logic                         In_ready,
    input  logic [LOG_PHYS:0]            Free_count,
    input  logic [WIDTH*LOG_PHYS-1:0]    Free_phys,
    output logic [$clog2(WIDTH+1)-1:0]   Free_pop,
    output logic [WIDTH-1:0]             Out_valid,
    output logic [WIDTH*LOG_PHYS-1:0]    Out_srcA_phys,
    output logic [WIDTH*LOG_PHYS-1:0]    Out_srcB_phys,
    output logic [WIDTH-1:0]             Out_srcA_rdy,
    output logic [WIDTH-1:0]             Out_srcB_rdy,
    output logic [WIDTH*LOG_PHYS-1:0]    Out_dst_phys,
    output logic [WIDTH*LOG_PHYS-1:0]    Out_old_phys,
    input  logic                         Out_ready,
    input  logic [WIDTH-1:0]             Wb_valid,
    input  logic [WIDTH*LOG_PHYS-1:0]    Wb_phys,
    input  logic [WIDTH-1:0]             Cm_valid,
    input  logic [WIDTH*LOG_ARCH-1:0]    Cm_arch,
    input  logic [WIDTH*LOG_PHYS-1:0]    Cm_phys,
    input  logic                         Flush
`ifdef RENAME_PERF_EN
    ,
    output logic [31:0]                  Stall_free_cnt,
    output logic [31:0]                  Stall_down_cnt
`endif
);

    localparam int unsigned NUM_ARCH = 1 << LOG_ARCH;
    localparam int unsigned NUM_PHYS = 1 << LOG_PHYS;
    localparam int unsigned POPW     = $clog2(WIDTH + 1);

    logic [LOG_PHYS-1:0]         r_frat [NUM_ARCH];
    logic [LOG_PHYS-1:0]         r_rrat [NUM_ARCH];
    logic [NUM_PHYS-1:0]         r_busy;

    logic [WIDTH-1:0]            r_out_valid;
    logic [WIDTH*LOG_PHYS-1:0]   r_out_sa;
    logic [WIDTH*LOG_PHYS-1:0]   r_out_sb;
    logic [WIDTH-1:0]            r_out_ra;
    logic [WIDTH-1:0]            r_out_rb;
    logic [WIDTH*LOG_PHYS-1:0]   r_out_dst;
    logic [WIDTH*LOG_PHYS-1:0]   r_out_old;

    logic [WIDTH-1:0]            w_ren;
    logic [POPW-1:0]             w_need;
    logic [LOG_PHYS-1:0]         w_new [WIDTH];
    logic [WIDTH*LOG_PHYS-1:0]   w_dst;
    logic [WIDTH*LOG_PHYS-1:0]   w_sa;
    logic [WIDTH*LOG_PHYS-1:0]   w_sb;
    logic [WIDTH-1:0]            w_ra;
    logic [WIDTH-1:0]            w_rb;
    logic [WIDTH*LOG_PHYS-1:0]   w_old;
    logic [LOG_ARCH-1:0]         w_arch_a;
    logic [LOG_ARCH-1:0]         w_arch_b;
    logic [LOG_ARCH-1:0]         w_arch_d;
    logic [LOG_ARCH-1:0]         w_arch_j;
    logic [NUM_PHYS-1:0]         w_wb_clr;
    logic [NUM_PHYS-1:0]         w_busy_eff;
    logic [NUM_PHYS-1:0]         w_busy_nx;
    logic [LOG_PHYS-1:0]         w_rrat_nx [NUM_ARCH];
    logic                        w_fits;
    logic                        w_accept;

    always_comb begin
        w_wb_clr = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (Wb_valid[i]) w_wb_clr[Wb_phys[i*LOG_PHYS +: LOG_PHYS]] = 1'b1;
        end
    end

    // A same-cycle writeback already makes the value available to a lookup.
    assign w_busy_eff = r_busy & ~w_wb_clr;

    always_comb begin
        w_need = '0;
        w_ren  = '0;
        w_dst  = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            w_new[k] = '0;
            if (In_valid[k] && In_regwrite[k] && (In_dst[k*LOG_ARCH +: LOG_ARCH] != '0)) begin
                w_ren[k] = 1'b1;
                w_new[k] = Free_phys[w_need*LOG_PHYS +: LOG_PHYS];
                w_need   = w_need + 1'b1;
            end
            w_dst[k*LOG_PHYS +: LOG_PHYS] = w_new[k];
        end
    end

    // Later earlier-slot writers overwrite earlier ones, leaving the nearest producer.
    always_comb begin
        w_sa     = '0;
        w_sb     = '0;
        w_ra     = '0;
        w_rb     = '0;
        w_old    = '0;
        w_arch_a = '0;
        w_arch_b = '0;
        w_arch_d = '0;
        w_arch_j = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            w_arch_a = In_srcA[k*LOG_ARCH +: LOG_ARCH];
            w_arch_b = In_srcB[k*LOG_ARCH +: LOG_ARCH];
            w_arch_d = In_dst[k*LOG_ARCH +: LOG_ARCH];
            w_sa[k*LOG_PHYS +: LOG_PHYS] = r_frat[w_arch_a];
            w_ra[k]                      = ~w_busy_eff[r_frat[w_arch_a]];
            w_sb[k*LOG_PHYS +: LOG_PHYS] = r_frat[w_arch_b];
            w_rb[k]                      = ~w_busy_eff[r_frat[w_arch_b]];
            if (w_ren[k]) w_old[k*LOG_PHYS +: LOG_PHYS] = r_frat[w_arch_d];
            for (int unsigned j = 0; j < WIDTH; j++) begin
                w_arch_j = In_dst[j*LOG_ARCH +: LOG_ARCH];
                if (j < k && w_ren[j]) begin
                    if (w_arch_j == w_arch_a) begin
                        w_sa[k*LOG_PHYS +: LOG_PHYS] = w_new[j];
                        w_ra[k]                      = 1'b0;
                    end
                    if (w_arch_j == w_arch_b) begin
                        w_sb[k*LOG_PHYS +: LOG_PHYS] = w_new[j];
                        w_rb[k]                      = 1'b0;
                    end
                    if (w_ren[k] && (w_arch_j == w_arch_d))
                        w_old[k*LOG_PHYS +: LOG_PHYS] = w_new[j];
                end
            end
            if (w_arch_a == '0) begin
                w_sa[k*LOG_PHYS +: LOG_PHYS] = '0;
                w_ra[k]                      = 1'b1;
            end
            if (w_arch_b == '0) begin
                w_sb[k*LOG_PHYS +: LOG_PHYS] = '0;
                w_rb[k]                      = 1'b1;
            end
        end
    end

    assign w_fits   = ((LOG_PHYS+1)'(w_need) <= Free_count);
    assign w_accept = RESET & ~Flush & In_valid[0] & w_fits & (~r_out_valid[0] | Out_ready);
    assign In_ready = w_accept;
    assign Free_pop = w_accept ? w_need : '0;

    always_comb begin
        w_busy_nx = w_busy_eff;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            if (w_accept && w_ren[k]) w_busy_nx[w_new[k]] = 1'b1;
        end
    end

    always_comb begin
        w_rrat_nx = r_rrat;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (Cm_valid[i])
                w_rrat_nx[Cm_arch[i*LOG_ARCH +: LOG_ARCH]] = Cm_phys[i*LOG_PHYS +: LOG_PHYS];
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int unsigned i = 0; i < NUM_ARCH; i++) begin
                r_frat[i] <= LOG_PHYS'(i);
                r_rrat[i] <= LOG_PHYS'(i);
            end
            r_busy      <= '0;
            r_out_valid <= '0;
            r_out_sa    <= '0;
            r_out_sb    <= '0;
            r_out_ra    <= '0;
            r_out_rb    <= '0;
            r_out_dst   <= '0;
            r_out_old   <= '0;
        end else begin
            r_rrat <= w_rrat_nx;
            if (Flush) begin
                r_frat      <= w_rrat_nx;
                r_busy      <= '0;
                r_out_valid <= '0;
            end else begin
                r_busy <= w_busy_nx;
                if (w_accept) begin
                    for (int unsigned k = 0; k < WIDTH; k++) begin
                        if (w_ren[k]) r_frat[In_dst[k*LOG_ARCH +: LOG_ARCH]] <= w_new[k];
                    end
                    r_out_valid <= In_valid;
                    r_out_sa    <= w_sa;
                    r_out_sb    <= w_sb;
                    r_out_ra    <= w_ra;
                    r_out_rb    <= w_rb;
                    r_out_dst   <= w_dst;
                    r_out_old   <= w_old;
                end else if (Out_ready) begin
                    r_out_valid <= '0;
                end
            end
        end
    end

    assign Out_valid     = r_out_valid;
    assign Out_srcA_phys = r_out_sa;
    assign Out_srcB_phys = r_out_sb;
    assign Out_srcA_rdy  = r_out_ra;
    assign Out_srcB_rdy  = r_out_rb;
    assign Out_dst_phys  = r_out_dst;
    assign Out_old_phys  = r_out_old;

`ifdef RENAME_PERF_EN
    logic        w_stall_free;
    logic        w_stall_down;
    logic [31:0] r_stall_free_cnt;
    logic [31:0] r_stall_down_cnt;

    // A free-list shortage takes precedence when both causes apply.
    assign w_stall_free = RESET & In_valid[0] & ~Flush & ~w_fits;
    assign w_stall_down = RESET & In_valid[0] & ~Flush & w_fits & r_out_valid[0] & ~Out_ready;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_stall_free_cnt <= '0;
            r_stall_down_cnt <= '0;
        end else begin
            if (w_stall_free && (r_stall_free_cnt != '1)) r_stall_free_cnt <= r_stall_free_cnt + 1'b1;
            if (w_stall_down && (r_stall_down_cnt != '1)) r_stall_down_cnt <= r_stall_down_cnt + 1'b1;
        end
    end

    assign Stall_free_cnt = r_stall_free_cnt;
    assign Stall_down_cnt = r_stall_down_cnt;
`endif

endmodule

// File: tb/tb_rename_nway.sv
// Directed bench for rename_nway (WIDTH=2) with an arch-level rename model checked every cycle.
module tb_rename_nway;

    localparam int W  = 2;
    localparam int LA = 5;
    localparam int LP = 6;

    logic            CLK = 1'b0;
    logic            RESET;
    logic [W-1:0]    In_valid, In_regwrite;
    logic [W*LA-1:0] In_srcA, In_srcB, In_dst;
    logic            In_ready;
    logic [LP:0]     Free_count;
    logic [W*LP-1:0] Free_phys;
    logic [1:0]      Free_pop;
    logic [W-1:0]    Out_valid, Out_srcA_rdy, Out_srcB_rdy;
    logic [W*LP-1:0] Out_srcA_phys, Out_srcB_phys, Out_dst_phys, Out_old_phys;
    logic            Out_ready;
    logic [W-1:0]    Wb_valid, Cm_valid;
    logic [W*LP-1:0] Wb_phys, Cm_phys;
    logic [W*LA-1:0] Cm_arch;
    logic            Flush;
`ifdef RENAME_PERF_EN
    logic [31:0]     Stall_free_cnt, Stall_down_cnt;
`endif

    rename_nway #(.WIDTH(W), .LOG_ARCH(LA), .LOG_PHYS(LP)) dut (
        .CLK(CLK), .RESET(RESET),
        .In_valid(In_valid), .In_srcA(In_srcA), .In_srcB(In_srcB), .In_dst(In_dst),
        .In_regwrite(In_regwrite), .In_ready(In_ready),
        .Free_count(Free_count), .Free_phys(Free_phys), .Free_pop(Free_pop),
        .Out_valid(Out_valid), .Out_srcA_phys(Out_srcA_phys), .Out_srcB_phys(Out_srcB_phys),
        .Out_srcA_rdy(Out_srcA_rdy), .Out_srcB_rdy(Out_srcB_rdy),
        .Out_dst_phys(Out_dst_phys), .Out_old_phys(Out_old_phys), .Out_ready(Out_ready),
        .Wb_valid(Wb_valid), .Wb_phys(Wb_phys),
        .Cm_valid(Cm_valid), .Cm_arch(Cm_arch), .Cm_phys(Cm_phys), .Flush(Flush)
`ifdef RENAME_PERF_EN
        , .Stall_free_cnt(Stall_free_cnt), .Stall_down_cnt(Stall_down_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int f6(input logic [W*LP-1:0] v, input int k);
        return int'(v[k*LP +: LP]);
    endfunction

    // ---------------- behavioural model ----------------
    int         m_frat [32];
    int         m_rrat [32];
    bit         m_busy [64];
    logic [1:0] e_valid;
    int         e_sa [2], e_sb [2], e_dst [2], e_old [2];
    bit         e_ra [2], e_rb [2];
    bit         t_ren [2];
    int         t_np [2], t_dd [2];

    function automatic bit wb_hit(input int ph);
        for (int i = 0; i < W; i++)
            if (Wb_valid[i] && int'(Wb_phys[i*LP +: LP]) == ph) return 1'b1;
        return 1'b0;
    endfunction

    // Nearest earlier in-group producer wins; otherwise the committed-speculative map.
    function automatic void look(input int src, input int k, output int ph, output bit rd);
        if (src == 0) begin ph = 0; rd = 1'b1; return; end
        for (int j = k - 1; j >= 0; j--)
            if (t_ren[j] && t_dd[j] == src) begin ph = t_np[j]; rd = 1'b0; return; end
        ph = m_frat[src];
        rd = !m_busy[ph] || wb_hit(ph);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin m_frat[i] = i; m_rrat[i] = i; end
        for (int i = 0; i < 64; i++) m_busy[i] = 1'b0;
        e_valid = '0;
    endtask

    task automatic model_cycle();
        int need, sa[2], sb[2], old[2];
        bit acc, ra[2], rb[2];
        need = 0;
        for (int k = 0; k < W; k++) begin
            t_dd[k]  = int'(In_dst[k*LA +: LA]);
            t_ren[k] = In_valid[k] && In_regwrite[k] && t_dd[k] != 0;
            t_np[k]  = 0;
            if (t_ren[k]) begin t_np[k] = int'(Free_phys[need*LP +: LP]); need++; end
        end
        acc = !Flush && In_valid[0] && need <= int'(Free_count) && (!e_valid[0] || Out_ready);
        chk("in_ready", In_ready, acc);
        chk("free_pop", Free_pop, acc ? need : 0);
        chk("out_valid", Out_valid, e_valid);
        for (int k = 0; k < W; k++) begin
            if (e_valid[k]) begin
                chk($sformatf("s%0d_srcA_phys", k), f6(Out_srcA_phys, k), e_sa[k]);
                chk($sformatf("s%0d_srcB_phys", k), f6(Out_srcB_phys, k), e_sb[k]);
                chk($sformatf("s%0d_srcA_rdy", k), Out_srcA_rdy[k], e_ra[k]);
                chk($sformatf("s%0d_srcB_rdy", k), Out_srcB_rdy[k], e_rb[k]);
                chk($sformatf("s%0d_dst_phys", k), f6(Out_dst_phys, k), e_dst[k]);
                chk($sformatf("s%0d_old_phys", k), f6(Out_old_phys, k), e_old[k]);
            end
        end
        for (int k = 0; k < W; k++) begin
            look(int'(In_srcA[k*LA +: LA]), k, sa[k], ra[k]);
            look(int'(In_srcB[k*LA +: LA]), k, sb[k], rb[k]);
            old[k] = 0;
            if (t_ren[k]) begin
                old[k] = m_frat[t_dd[k]];
                for (int j = k - 1; j >= 0; j--)
                    if (t_ren[j] && t_dd[j] == t_dd[k]) begin old[k] = t_np[j]; break; end
            end
        end
        for (int i = 0; i < W; i++)
            if (Cm_valid[i]) m_rrat[int'(Cm_arch[i*LA +: LA])] = int'(Cm_phys[i*LP +: LP]);
        if (Flush) begin
            for (int i = 0; i < 32; i++) m_frat[i] = m_rrat[i];
            for (int i = 0; i < 64; i++) m_busy[i] = 1'b0;
            e_valid = '0;
        end else begin
            for (int i = 0; i < 64; i++) if (wb_hit(i)) m_busy[i] = 1'b0;
            if (acc) begin
                for (int k = 0; k < W; k++) begin
                    if (t_ren[k]) begin m_busy[t_np[k]] = 1'b1; m_frat[t_dd[k]] = t_np[k]; end
                    e_sa[k] = sa[k]; e_sb[k] = sb[k]; e_ra[k] = ra[k]; e_rb[k] = rb[k];
                    e_dst[k] = t_np[k]; e_old[k] = old[k];
                end
                e_valid = In_valid;
            end else if (Out_ready) begin
                e_valid = '0;
            end
        end
    endtask

    always @(negedge CLK) begin
        if (!RESET) begin
            model_reset();
            chk("rst_out_valid", Out_valid, 0);
            chk("rst_out_data", {Out_srcA_phys, Out_srcB_phys, Out_dst_phys, Out_old_phys}, 0);
            chk("rst_out_rdy", {Out_srcA_rdy, Out_srcB_rdy}, 0);
            chk("rst_in_ready", In_ready, 0);
            chk("rst_free_pop", Free_pop, 0);
        end else begin
            model_cycle();
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        In_valid = '0; In_regwrite = '0; In_srcA = '0; In_srcB = '0; In_dst = '0;
        Wb_valid = '0; Wb_phys = '0; Cm_valid = '0; Cm_arch = '0; Cm_phys = '0;
        Flush = 1'b0; Out_ready = 1'b1; Free_count = 7'd20;
    endtask

    task automatic slot(input int k, input int sa, input int sb, input int d, input bit w);
        In_valid[k] = 1'b1;
        In_regwrite[k] = w;
        In_srcA[k*LA +: LA] = 5'(sa);
        In_srcB[k*LA +: LA] = 5'(sb);
        In_dst[k*LA +: LA] = 5'(d);
    endtask

    task automatic fp(input int f0, input int f1);
        Free_phys = {6'(f1), 6'(f0)};
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    logic [63:0] snap;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b0;
        idle();
        Free_phys = '0;
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b1;

        // Dependent pair r3<-r1,r2 ; r4<-r3,r3
        idle(); slot(0, 1, 2, 3, 1); slot(1, 3, 3, 4, 1); fp(40, 41);
        #1;
        chk("t1_in_ready", In_ready, 1);
        chk("t1_free_pop", Free_pop, 2);
        step();
        chk("t1_dst0", f6(Out_dst_phys, 0), 40);
        chk("t1_dst1", f6(Out_dst_phys, 1), 41);
        chk("t1_s1_srcA", f6(Out_srcA_phys, 1), 40);
        chk("t1_s1_srcB", f6(Out_srcB_phys, 1), 40);
        chk("t1_s1_rdy", {Out_srcA_rdy[1], Out_srcB_rdy[1]}, 0);
        chk("t1_old", {f6(Out_old_phys, 1), f6(Out_old_phys, 0)}, {32'd4, 32'd3});
        chk("t1_s0_srcA", {f6(Out_srcA_phys, 0), 31'd0, Out_srcA_rdy[0]}, {32'd1, 32'd1});

        // Lookup of r3 with writeback of 40 in the same cycle
        idle(); slot(0, 3, 4, 6, 1); fp(42, 43);
        Wb_valid = 2'b01; Wb_phys[LP-1:0] = 6'd40;
        #1;
        chk("wb_free_pop", Free_pop, 1);
        step();
        chk("wb_srcA", {f6(Out_srcA_phys, 0), 31'd0, Out_srcA_rdy[0]}, {32'd40, 32'd1});
        chk("wb_srcB", {f6(Out_srcB_phys, 0), 31'd0, Out_srcB_rdy[0]}, {32'd41, 32'd0});

        // Both slots write r5
        idle(); slot(0, 0, 0, 5, 1); slot(1, 5, 0, 5, 1); fp(50, 51);
        step();
        chk("t2_dst", {f6(Out_dst_phys, 1), f6(Out_dst_phys, 0)}, {32'd51, 32'd50});
        chk("t2_old", {f6(Out_old_phys, 1), f6(Out_old_phys, 0)}, {32'd50, 32'd5});
        chk("t2_s1_srcA", {f6(Out_srcA_phys, 1), 31'd0, Out_srcA_rdy[1]}, {32'd50, 32'd0});
        chk("t2_s0_srcA", {f6(Out_srcA_phys, 0), 31'd0, Out_srcA_rdy[0]}, {32'd0, 32'd1});
        chk("t2_model_frat5", m_frat[5], 51);

        // Free list short by one: whole group refused
        idle(); slot(0, 5, 0, 8, 1); slot(1, 8, 0, 9, 1); fp(52, 53); Free_count = 7'd1;
        #1;
        chk("t3_in_ready", In_ready, 0);
        chk("t3_free_pop", Free_pop, 0);
        step();
        chk("t3_out_valid", Out_valid, 0);
        Free_count = 7'd2;
        #1;
        chk("t3b_in_ready", In_ready, 1);
        step();
        chk("t3b_s0_srcA", {f6(Out_srcA_phys, 0), 31'd0, Out_srcA_rdy[0]}, {32'd51, 32'd0});
        chk("t3b_s1_srcA", f6(Out_srcA_phys, 1), 52);
        chk("t3b_dst", {f6(Out_dst_phys, 1), f6(Out_dst_phys, 0)}, {32'd53, 32'd52});

        // Downstream stall for three cycles with a new group waiting
        snap = {Out_valid, Out_srcA_phys, Out_dst_phys, Out_old_phys, Out_srcA_rdy, Out_srcB_rdy};
        idle(); Out_ready = 1'b0; slot(0, 8, 9, 10, 1); slot(1, 10, 1, 11, 1); fp(54, 55);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("t4_in_ready_hold", In_ready, 0);
            step();
            chk("t4_out_stable",
                {Out_valid, Out_srcA_phys, Out_dst_phys, Out_old_phys, Out_srcA_rdy, Out_srcB_rdy}, snap);
        end
        Out_ready = 1'b1;
        #1;
        chk("t4_in_ready_go", In_ready, 1);
        step();
        chk("t4_dst", {f6(Out_dst_phys, 1), f6(Out_dst_phys, 0)}, {32'd55, 32'd54});
        chk("t4_s0_src", {f6(Out_srcA_phys, 0), f6(Out_srcB_phys, 0)}, {32'd52, 32'd53});
        chk("t4_s1_src", {f6(Out_srcA_phys, 1), f6(Out_srcB_phys, 1)}, {32'd54, 32'd1});
`ifdef RENAME_PERF_EN
        chk("perf_stall_free", Stall_free_cnt, 1);
        chk("perf_stall_down", Stall_down_cnt, 3);
`endif

        // Allocate 56 while a writeback of 56 arrives: stays busy
        idle(); slot(0, 0, 0, 12, 1); fp(56, 57);
        Wb_valid = 2'b01; Wb_phys[LP-1:0] = 6'd56;
        step();
        chk("t5_dst0", f6(Out_dst_phys, 0), 56);
        idle(); slot(0, 12, 0, 13, 1); fp(58, 59);
        step();
        chk("t5_srcA", {f6(Out_srcA_phys, 0), 31'd0, Out_srcA_rdy[0]}, {32'd56, 32'd0});

        // Speculative r3->45, commits, then flush with a same-cycle commit r3->40
        idle(); slot(0, 1, 1, 3, 1); fp(45, 46);
        step();
        chk("t6_dst0", f6(Out_dst_phys, 0), 45);
        idle(); Cm_valid = 2'b11;
        Cm_arch = {5'd9, 5'd9}; Cm_phys = {6'd21, 6'd20};
        step();
        idle(); Cm_valid = 2'b01; Cm_arch[LA-1:0] = 5'd3; Cm_phys[LP-1:0] = 6'd40; Flush = 1'b1;
        slot(0, 1, 1, 14, 1); fp(60, 61);
        #1;
        chk("t6_flush_in_ready", In_ready, 0);
        chk("t6_flush_free_pop", Free_pop, 0);
        step();
        chk("t6_flush_out_valid", Out_valid, 0);
        chk("t6_model_frat3", m_frat[3], 40);
        idle(); slot(0, 3, 9, 15, 1); slot(1, 13, 4, 16, 1); fp(60, 61);
        step();
        chk("t6_s0_src", {f6(Out_srcA_phys, 0), f6(Out_srcB_phys, 0)}, {32'd40, 32'd21});
        chk("t6_s1_src", {f6(Out_srcA_phys, 1), f6(Out_srcB_phys, 1)}, {32'd13, 32'd4});
        chk("t6_rdy", {Out_srcA_rdy, Out_srcB_rdy}, 4'b1111);

        // Asynchronous reset in the middle of a cycle
        idle(); slot(0, 0, 0, 17, 1); fp(62, 63);
        step();
        idle();
        #2;
        RESET = 1'b0;
        #1;
        chk("t7_async_out_valid", Out_valid, 0);
        chk("t7_async_dst", Out_dst_phys, 0);
        step();
        RESET = 1'b1;
        idle(); slot(0, 3, 17, 18, 1); fp(32, 33);
        step();
        chk("t7_src", {f6(Out_srcA_phys, 0), f6(Out_srcB_phys, 0)}, {32'd3, 32'd17});
        chk("t7_old_dst", {f6(Out_old_phys, 0), f6(Out_dst_phys, 0)}, {32'd18, 32'd32});

        // Nothing to rename: accepted even with an empty free list
        idle(); slot(0, 0, 0, 0, 1); slot(1, 1, 0, 19, 0); Free_count = 7'd0;
        #1;
        chk("t8_in_ready", In_ready, 1);
        chk("t8_free_pop", Free_pop, 0);
        step();
        chk("t8_out", {Out_valid, Out_dst_phys}, {2'b11, 12'd0});

        idle();
        step();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
